// File: rtl/b002_encoder_if.sv
// AXI-stream style payload channel feeding the IRIG-B002 encoder.
// One beat carries a full 100-bit frame image.
interface b002_encoder_if #(
    parameter int W = 100
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/b002_encoder.sv
// IRIG-B002 pulse-width encoder: 100 bits per frame, markers at 0 and 9,19..99.
// A one-entry shadow buffer decouples payload delivery from frame timing.
module b002_encoder #(
    parameter int BIT_PERIOD = 500000,
    parameter int WIDTH_0    = 100000,
    parameter int WIDTH_1    = 250000,
    parameter int WIDTH_P    = 400000
) (
    input  logic            clk_50MHz,
    input  logic            reset,
    input  logic            enable,
    b002_encoder_if.slave   s_axis,
    output logic            irig_out,
    output logic            frame_start,
    output logic            underrun,
    output logic            busy
);
    localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CW-1:0] BP_LAST = CW'(BIT_PERIOD - 1);
    localparam logic [CW-1:0] W0 = CW'(WIDTH_0);
    localparam logic [CW-1:0] W1 = CW'(WIDTH_1);
    localparam logic [CW-1:0] WP = CW'(WIDTH_P);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_n;
    logic [CW-1:0] clk_cnt, cnt_n;
    logic [6:0]    bit_idx, idx_n;
    logic [99:0]   shadow, active;
    logic          shadow_valid;
    logic          accept, load, under_n;
    logic          is_mark;
    logic [CW-1:0] width;
    logic          unused_tlast;

    assign s_axis.tready = ~shadow_valid;
    assign accept        = s_axis.tvalid & ~shadow_valid;
    assign unused_tlast  = s_axis.tlast;

    assign is_mark = (bit_idx == 7'd0) || ((bit_idx % 7'd10) == 7'd9);

    always_comb begin
        width = W0;
        if (is_mark)
            width = WP;
        else if (active[bit_idx])
            width = W1;
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_n;
            clk_cnt <= cnt_n;
            bit_idx <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = clk_cnt;
        idx_n   = bit_idx;
        load    = 1'b0;
        under_n = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (enable && shadow_valid) begin
                    state_n = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (clk_cnt == BP_LAST) begin
                    cnt_n = '0;
                    if (bit_idx == 7'd99) begin
                        idx_n = '0;
                        // enable is only honoured at frame boundaries
                        if (!enable)
                            state_n = IDLE;
                        else if (shadow_valid)
                            load = 1'b1;
                        else
                            under_n = 1'b1;
                    end else begin
                        idx_n = bit_idx + 7'd1;
                    end
                end else begin
                    cnt_n = clk_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset)
            shadow_valid <= 1'b0;
        else if (accept)
            shadow_valid <= 1'b1;
        else if (load)
            shadow_valid <= 1'b0;
    end

    always_ff @(posedge clk_50MHz) begin
        if (accept)
            shadow <= s_axis.tdata;
        if (load)
            active <= shadow;
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            irig_out    <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            irig_out    <= (state == RUN) && (clk_cnt < width);
            frame_start <= (state == RUN) && (clk_cnt == '0) &&
                           (bit_idx == '0);
            underrun    <= under_n;
            busy        <= (state_n == RUN);
        end
    end
endmodule

// File: tb/tb_b002_encoder.sv
// Bench for b002_encoder: scoreboard of expected pulse widths per bit,
// table of per-frame bit checks, and hand sequences for timing corners.
module tb_b002_encoder;
    localparam int BP = 20;
    localparam int W0 = 4;
    localparam int W1 = 10;
    localparam int WP = 16;
    localparam int FRAME = 100 * BP;

    logic clk_50MHz = 1'b0;
    logic reset;
    logic enable;
    logic irig_out, frame_start, underrun, busy;

    b002_encoder_if #(.W(100)) s_axis ();

    b002_encoder #(
        .BIT_PERIOD(BP),
        .WIDTH_0(W0),
        .WIDTH_1(W1),
        .WIDTH_P(WP)
    ) dut (
        .clk_50MHz  (clk_50MHz),
        .reset      (reset),
        .enable     (enable),
        .s_axis     (s_axis),
        .irig_out   (irig_out),
        .frame_start(frame_start),
        .underrun   (underrun),
        .busy       (busy)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk_50MHz) cyc++;

    int exp_q[$];
    int meas[8][100];
    int fs_cyc[8];
    int fn = 0;
    int mon_idx = 0;
    int run = 0;
    int ur_cnt = 0;
    int ur_cyc = -1;
    int e_w;
    logic prev = 1'b0;

    typedef struct {
        string name;
        int    frame;
        int    pos;
        int    exp_w;
    } vec_t;
    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Expected width of each bit, derived from the B002 code rules
    task automatic push_frame(input logic [99:0] d);
        for (int i = 0; i < 100; i++) begin
            if (i == 0 || (i % 10) == 9)
                exp_q.push_back(WP);
            else
                exp_q.push_back(d[i] ? W1 : W0);
        end
    endtask

    // Monitor: measure every high pulse and compare to the scoreboard
    always @(negedge clk_50MHz) begin
        if (reset) begin
            prev = 1'b0;
            run = 0;
            mon_idx = 0;
            exp_q.delete();
        end else begin
            if (frame_start) begin
                fn++;
                if (fn < 8) fs_cyc[fn] = cyc;
                mon_idx = 0;
                chk("fs_with_irig", {31'd0, irig_out}, 32'd1);
            end
            if (underrun) begin
                ur_cnt++;
                ur_cyc = cyc;
            end
            if (irig_out) begin
                run++;
            end else if (prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pulse_unexpected got=%0d want=none", run);
                end else begin
                    e_w = exp_q.pop_front();
                    chk($sformatf("pulse_f%0d_b%0d", fn, mon_idx), run, e_w);
                end
                if (fn < 8 && mon_idx < 100) meas[fn][mon_idx] = run;
                mon_idx++;
                run = 0;
            end
            prev = irig_out;
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk_50MHz);
            #1;
        end
    endtask

    task automatic wait_frame(input int n);
        for (int i = 0; i < FRAME + 200 && fn < n; i++) begin
            @(posedge clk_50MHz);
            #1;
        end
        chk($sformatf("frame%0d_seen", n), {31'd0, fn >= n}, 32'd1);
    endtask

    task automatic send_beat(input logic [99:0] d, input int budget,
                             output int acc_cyc);
        bit got;
        got = 1'b0;
        s_axis.tdata = d;
        s_axis.tvalid = 1'b1;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk_50MHz);
            got = s_axis.tready;
            @(posedge clk_50MHz);
            #1;
        end
        s_axis.tvalid = 1'b0;
        acc_cyc = cyc;
        chk("beat_accept", {31'd0, got}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    logic [99:0] p2, p3, p4, p5;
    int n0, acc, hi, lo;

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        s_axis.tdata = '0;
        s_axis.tvalid = 1'b0;
        s_axis.tlast = 1'b0;
        for (int f = 0; f < 8; f++) begin
            fs_cyc[f] = -1;
            for (int i = 0; i < 100; i++) meas[f][i] = -1;
        end

        p2 = '0;
        p2[1] = 1'b1;
        p2[10] = 1'b1;
        p2[19] = 1'b1;
        p2[98] = 1'b1;
        p3 = '1;
        p4 = '0;
        p4[30] = 1'b1;
        p5 = '0;
        p5[3] = 1'b1;

        vecs[0]  = '{"f1_ref_marker", 1, 0, WP};
        vecs[1]  = '{"f1_bit1_zero", 1, 1, W0};
        vecs[2]  = '{"f1_marker9", 1, 9, WP};
        vecs[3]  = '{"f1_bit50_zero", 1, 50, W0};
        vecs[4]  = '{"f1_marker99", 1, 99, WP};
        vecs[5]  = '{"f2_repeat_bit1", 2, 1, W0};
        vecs[6]  = '{"f3_bit1_one", 3, 1, W1};
        vecs[7]  = '{"f3_bit2_zero", 3, 2, W0};
        vecs[8]  = '{"f3_marker9", 3, 9, WP};
        vecs[9]  = '{"f3_bit10_one", 3, 10, W1};
        vecs[10] = '{"f3_marker19_ovr", 3, 19, WP};
        vecs[11] = '{"f3_bit98_one", 3, 98, W1};
        vecs[12] = '{"f4_ones_bit55", 4, 55, W1};
        vecs[13] = '{"f4_marker99", 4, 99, WP};
        vecs[14] = '{"f6_bit3_one", 6, 3, W1};
        vecs[15] = '{"f6_bit4_zero", 6, 4, W0};

        repeat (3) @(posedge clk_50MHz);
        #1;
        chk("rst_irig", {31'd0, irig_out}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_tready", {31'd0, s_axis.tready}, 1);
        chk("rst_fs", {31'd0, frame_start}, 0);
        chk("rst_underrun", {31'd0, underrun}, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk_50MHz);
        #1;

        // First frame: all-zero payload, latency from the accepting edge
        enable = 1'b1;
        push_frame('0);
        send_beat('0, 10, n0);
        chk("tready_after_beat", {31'd0, s_axis.tready}, 0);
        wait_cyc(n0 + 1);
        chk("busy_n1", {31'd0, busy}, 1);
        chk("irig_n1", {31'd0, irig_out}, 0);
        chk("tready_n1", {31'd0, s_axis.tready}, 1);
        wait_cyc(n0 + 2);
        chk("irig_n2", {31'd0, irig_out}, 1);
        chk("fs_n2", {31'd0, frame_start}, 1);
        wait_cyc(n0 + 17);
        chk("irig_n17", {31'd0, irig_out}, 1);
        wait_cyc(n0 + 18);
        chk("irig_n18", {31'd0, irig_out}, 0);

        // No new beat: the frame repeats with an underrun strobe
        push_frame('0);
        wait_frame(2);
        chk("fs1_cycle", fs_cyc[1], n0 + 2);
        chk("fs_gap", fs_cyc[2] - fs_cyc[1], FRAME);
        chk("underrun_cnt", ur_cnt, 1);
        chk("underrun_cyc", ur_cyc, fs_cyc[1] + FRAME - 1);

        // Two beats during frame 2: the second waits for the boundary
        push_frame(p2);
        send_beat(p2, 50, acc);
        @(posedge clk_50MHz);
        #1;
        chk("slot_held", {31'd0, s_axis.tready}, 0);
        push_frame(p3);
        send_beat(p3, FRAME + 100, acc);
        wait_frame(3);
        chk("slot_reopen", acc, fs_cyc[3]);
        chk("no_underrun", ur_cnt, 1);

        // Drop enable at bit 50 of frame 4: it must still complete
        wait_frame(4);
        wait_cyc(fs_cyc[4] + 50 * BP);
        enable = 1'b0;
        wait_cyc(fs_cyc[4] + FRAME - 2);
        chk("busy_end_frame", {31'd0, busy}, 1);
        wait_cyc(fs_cyc[4] + FRAME - 1);
        chk("busy_after_frame", {31'd0, busy}, 0);
        hi = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk_50MHz);
            #1;
            if (irig_out || busy) hi++;
        end
        chk("idle_quiet", hi, 0);
        chk("idle_frames", fn, 4);
        chk("idle_no_underrun", ur_cnt, 1);
        chk("queue_drained", exp_q.size(), 0);

        // Reset during the high time of bit 30
        enable = 1'b1;
        push_frame(p4);
        send_beat(p4, 10, acc);
        wait_frame(5);
        wait_cyc(fs_cyc[5] + 30 * BP + 5);
        chk("bit30_high", {31'd0, irig_out}, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_irig", {31'd0, irig_out}, 0);
        chk("rst_mid_busy", {31'd0, busy}, 0);
        chk("rst_mid_tready", {31'd0, s_axis.tready}, 1);
        @(posedge clk_50MHz);
        #1;
        reset = 1'b0;
        hi = 0;
        lo = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_50MHz);
            #1;
            if (irig_out || busy) hi++;
            if (!s_axis.tready) lo++;
        end
        chk("post_rst_quiet", hi, 0);
        chk("post_rst_tready", lo, 0);
        chk("post_rst_frames", fn, 5);

        push_frame(p5);
        send_beat(p5, 10, acc);
        wait_cyc(acc + 1);
        chk("restart_busy", {31'd0, busy}, 1);
        wait_frame(6);
        wait_cyc(fs_cyc[6] + 15 * BP);

        for (int i = 0; i < 16; i++)
            chk(vecs[i].name, meas[vecs[i].frame][vecs[i].pos], vecs[i].exp_w);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
